uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a word FIFO, baud-rate divider and valid/ready input handshake. It is the successor to the board-level button-driven transmitter: it drives the `Tx` pin from a stream of words pushed by on-chip logic. It sends one bit per `CLKS_PER_BIT` clocks instead of one bit per clock. Data width, stop bits and FIFO depth are configurable, and parity is optional.

---
 rtl/uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a word FIFO with a valid/ready push port.
// One bit is sent per CLKS_PER_BIT clocks, LSB first, with configurable data and stop bits.
// Optional parity bit: define UART_TX_PARITY_EN to build the PARITY state (PARITY_ODD picks odd/even).
// Tx and busy are registered from the current FSM state, so the line lags the state by one clock.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic                 CLOCK_125_p,
  input  logic                 KEY0,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // Elaboration-time guard against out-of-range parameters.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_par
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end
  if (FIFO_AW < 1 || FIFO_AW > 8) begin : g_bad_aw
    $error("uart_tx_fifo: FIFO_AW out of range");
  end

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 tx_ready_q;
  logic                 push_c, pop_c;
  logic [DATA_BITS-1:0] rd_word_c;

  // Serializer state
  logic [2:0]           state_q, state_n;
  logic [BAUD_W-1:0]    baud_q, baud_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 tx_q, tx_n;
  logic                 busy_q, busy_n;
  logic                 baud_end_c;
  logic                 fifo_has_word_c;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign push_c          = tx_valid & tx_ready_q;
  assign rd_word_c       = mem[rd_ptr_q];
  assign fifo_has_word_c = (count_q != CNT_W'(0));
  assign baud_end_c      = (baud_q == BAUD_LAST);

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_n = count_q;
    case ({push_c, pop_c})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  // FIFO storage write; contents need no reset, pointers define validity
  always_ff @(posedge CLOCK_125_p) begin
    if (push_c) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge CLOCK_125_p) begin
    if (!KEY0) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      count_q    <= count_n;
      tx_ready_q <= (count_n != FULL_COUNT);
    end
  end

  // FSM next state, counters, pop request and next line value
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    pop_c   = 1'b0;
    tx_n    = 1'b1;
    busy_n  = (state_q != ST_IDLE);
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (fifo_has_word_c) begin
          pop_c   = 1'b1;
          state_n = ST_START;
        end
      end

      ST_START: begin
        tx_n = 1'b0;
        if (baud_end_c) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        tx_n = shift_q[0];
        if (baud_end_c) begin
          baud_n  = '0;
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_n = par_q;
        if (baud_end_c) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_STOP;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
`endif

      ST_STOP: begin
        tx_n = 1'b1;
        if (baud_end_c) begin
          baud_n = '0;
          if (bit_q == STOP_LAST) begin
            bit_n = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (fifo_has_word_c) begin
              pop_c   = 1'b1;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase

    // Load the popped word; parity comes from the stored word, not live input.
    if (pop_c) begin
      shift_n = rd_word_c;
`ifdef UART_TX_PARITY_EN
      par_n   = (^rd_word_c) ^ PARITY_ODD[0];
`endif
    end
  end

  // FSM state, counters and registered line outputs
  always_ff @(posedge CLOCK_125_p) begin
    if (!KEY0) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign Tx         = tx_q;
  assign busy       = busy_q;
  assign tx_ready   = tx_ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances cover even parity, odd parity and
// a 5-data/2-stop frame; frames are checked bit by bit against a small frame model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F_MAIN = (1 + 8 + P + 1) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       key0;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       tx0, tx1, tx2;
  logic       b0, b1, b2;
  logic [2:0] c0, c1, c2;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0), .FIFO_AW(2)) u_dut (
    .CLOCK_125_p(clk), .KEY0(key0), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
    .Tx(tx0), .busy(b0), .fifo_count(c0));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1), .FIFO_AW(2)) u_odd (
    .CLOCK_125_p(clk), .KEY0(key0), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .Tx(tx1), .busy(b1), .fifo_count(c1));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0), .FIFO_AW(2)) u_s2 (
    .CLOCK_125_p(clk), .KEY0(key0), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
    .Tx(tx2), .busy(b2), .fifo_count(c2));

  int         sel;
  logic       tx_mon, busy_mon, ready_mon;
  logic [2:0] count_mon;
  int         n_tests, n_fail, busy_cycles;

  // Route the selected instance's outputs to the checkers.
  always_comb begin
    case (sel)
      1:       begin tx_mon = tx1; busy_mon = b1; ready_mon = r1; count_mon = c1; end
      2:       begin tx_mon = tx2; busy_mon = b2; ready_mon = r2; count_mon = c2; end
      default: begin tx_mon = tx0; busy_mon = b0; ready_mon = r0; count_mon = c0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      1:       begin v1 = v; d1 = d; end
      2:       begin v2 = v; d2 = d[4:0]; end
      default: begin v0 = v; d0 = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      if (tx_mon == 1'b0) break;
      step();
    end
    check({tag, "_fall"}, 32'(tx_mon), 32'd0);
  endtask

  // Checks one frame starting at the first start-bit clock; each bit must hold CPB clocks.
  task automatic run_frame(input logic [8:0] word, input int nd, input int ns, input string tag,
                           input logic odd);
    logic        exp_bits [16];
    int          nb;
    logic        par;
    logic [31:0] obs;
    nb = 0;
    exp_bits[nb] = 1'b0; nb++;
    par = odd;
    for (int i = 0; i < nd; i++) begin
      exp_bits[nb] = word[i]; nb++;
      par = par ^ word[i];
    end
    if (P == 1) begin
      exp_bits[nb] = par; nb++;
    end
    for (int i = 0; i < ns; i++) begin
      exp_bits[nb] = 1'b1; nb++;
    end
    for (int b = 0; b < nb; b++) begin
      obs = 32'(tx_mon);
      for (int c = 0; c < CPB; c++) begin
        if (32'(tx_mon) != obs) obs = 32'd2;
        if (busy_mon) busy_cycles++;
        step();
      end
      check($sformatf("%s_bit%0d", tag, b), obs, 32'(exp_bits[b]));
    end
  endtask

  // One word into an idle instance: pop one edge later, Tx low two edges later.
  task automatic single_frame(input int idx, input logic [7:0] word, input int nd, input int ns,
                              input logic odd, input string tag);
    int f;
    f = (1 + nd + P + ns) * CPB;
    sel = idx;
    drive(1'b1, word);
    step();
    drive(1'b0, 8'h00);
    check({tag, "_cnt_push"}, 32'(count_mon), 32'd1);
    check({tag, "_tx_hold"}, 32'(tx_mon), 32'd1);
    step();
    check({tag, "_cnt_pop"}, 32'(count_mon), 32'd0);
    check({tag, "_tx_pre"}, 32'(tx_mon), 32'd1);
    step();
    check({tag, "_fall"}, 32'(tx_mon), 32'd0);
    busy_cycles = 0;
    run_frame(9'(word), nd, ns, tag, odd);
    check({tag, "_busy_len"}, 32'(busy_cycles), 32'(f));
    check({tag, "_busy_end"}, 32'(busy_mon), 32'd0);
    check({tag, "_tx_end"}, 32'(tx_mon), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   acc [6];
    int   cyc, k, low_cycles;
    logic rdy;
    n_tests = 0; n_fail = 0; busy_cycles = 0; sel = 0;
    key0 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_ready", 32'(r0), 32'd1);
    check("rst_count", 32'(c0), 32'd0);
    key0 = 1'b1;
    step();

    // 0xA5, even parity: 0,1,0,1,0,0,1,0,1,(0),1
    single_frame(0, 8'hA5, 8, 1, 1'b0, "t1");
    step();
    // 0x01 with odd parity: parity bit is 0
    single_frame(1, 8'h01, 8, 1, 1'b1, "t2");
    step();
    // 5 data bits, 2 stop bits, 0x1F: parity 1
    single_frame(2, 8'h1F, 5, 2, 1'b0, "t4");
    step();

    // Burst of 6 words: the first pops at once, 2..5 fill the FIFO, 6 waits for a free slot.
    sel = 0;
    fork
      begin
        for (k = 0; k < 6; k++) acc[k] = -1;
        cyc = -1; k = 0;
        drive(1'b1, 8'h00);
        while (k < 6 && cyc < 400) begin
          rdy = ready_mon;
          step();
          cyc++;
          if (rdy) begin
            acc[k] = cyc;
            k++;
            if (k == 6) drive(1'b0, 8'h00);
            else drive(1'b1, 8'(k));
            if (k == 5) begin
              check("t3_ready_full", 32'(ready_mon), 32'd0);
              check("t3_count_full", 32'(count_mon), 32'd4);
            end
          end
          if (cyc == F_MAIN + 1) begin
            check("t3_ready_back", 32'(ready_mon), 32'd1);
            check("t3_count_back", 32'(count_mon), 32'd3);
          end
        end
        check("t3_accepted", 32'(k), 32'd6);
        check("t3_acc5_edge", 32'(acc[4]), 32'd4);
        check("t3_acc6_edge", 32'(acc[5]), 32'(F_MAIN + 2));
      end
      begin
        wait_fall(10, "t3");
        for (int w = 0; w < 6; w++) run_frame(9'(w), 8, 1, $sformatf("t3_w%0d", w), 1'b0);
        check("t3_busy_end", 32'(busy_mon), 32'd0);
      end
    join
    step();

    // Push coinciding with the stop-end pop at count 2: count holds, order preserved.
    fork
      begin
        drive(1'b1, 8'h11); step();
        drive(1'b1, 8'h22); step();
        check("t6_cnt_pp_idle", 32'(count_mon), 32'd1);
        drive(1'b1, 8'h33); step();
        drive(1'b0, 8'h00);
        check("t6_cnt2", 32'(count_mon), 32'd2);
        repeat (F_MAIN - 2) @(posedge clk);
        #1;
        check("t6_cnt_before", 32'(count_mon), 32'd2);
        drive(1'b1, 8'h44); step();
        drive(1'b0, 8'h00);
        check("t6_cnt_pushpop", 32'(count_mon), 32'd2);
      end
      begin
        wait_fall(10, "t6");
        run_frame(9'h011, 8, 1, "t6_w0", 1'b0);
        run_frame(9'h022, 8, 1, "t6_w1", 1'b0);
        run_frame(9'h033, 8, 1, "t6_w2", 1'b0);
        run_frame(9'h044, 8, 1, "t6_w3", 1'b0);
      end
    join
    step();

    // Reset pulse mid-DATA with two words queued aborts everything.
    drive(1'b1, 8'hA1); step();
    drive(1'b1, 8'hB2); step();
    drive(1'b1, 8'hC3); step();
    drive(1'b0, 8'h00);
    wait_fall(10, "t5");
    repeat (8) @(posedge clk);
    #1;
    check("t5_cnt_queued", 32'(count_mon), 32'd2);
    key0 = 1'b0;
    step();
    key0 = 1'b1;
    check("t5_tx", 32'(tx_mon), 32'd1);
    check("t5_busy", 32'(busy_mon), 32'd0);
    check("t5_count", 32'(count_mon), 32'd0);
    check("t5_ready", 32'(ready_mon), 32'd1);
    low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_mon == 1'b0 || busy_mon == 1'b1) low_cycles++;
      step();
    end
    check("t5_quiet", 32'(low_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
